// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply sequencer: op encodings,
// FSM state type and the default datapath width.
package mul_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] FUNC3_MUL   = 3'b000;
    localparam logic [2:0] FUNC3_MULHU = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic func3_legal(input logic [2:0] f);
        return (f == FUNC3_MUL) || (f == FUNC3_MULHU);
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the EX stage and the multiply sequencer.
interface mul_sequencer_if #(
    parameter int DATA_W = mul_pkg::DATA_W_DEF
);
    logic              start;
    logic [2:0]        func3;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              flush;
    logic              stall;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        output start, func3, op_a, op_b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, func3, op_a, op_b, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add datapath: holds the multiplicand and the double-width
// product register, and exposes the product value after the next step.
module mul_shift_add_dp #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic [DATA_W-1:0]   load_a,
    input  logic [DATA_W-1:0]   load_b,
    output logic [2*DATA_W-1:0] prod_next
);
    logic [DATA_W-1:0]   mcand_reg;
    logic [2*DATA_W-1:0] prod_reg;
    logic [DATA_W-1:0]   addend;
    logic [DATA_W:0]     sum;

    // Partial product for this cycle: mcand gated by the current multiplier LSB.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & prod_reg[0];
        end
    endgenerate

    // The extra sum bit carries into the shifted-down high half.
    assign sum       = {1'b0, prod_reg[2*DATA_W-1:DATA_W]} + {1'b0, addend};
    assign prod_next = {sum, prod_reg[DATA_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg <= '0;
            prod_reg  <= '0;
        end else if (load) begin
            mcand_reg <= load_a;
            prod_reg  <= {{DATA_W{1'b0}}, load_b};
        end else if (step) begin
            prod_reg  <= prod_next;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative multiply sequencer for the EX stage: fixed-latency MUL/MULHU,
// stalls the pipeline while running and pulses done with the product.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    mul_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [2:0]          func3_reg;
    logic [DATA_W-1:0]   result_reg;
    logic                done_reg;
    logic                busy_reg;
    logic                accept;
    logic                load;
    logic                step;
    logic                last_step;
    logic [2*DATA_W-1:0] prod_next;

    assign accept    = (state_reg == IDLE) && bus.start && !bus.flush;
    assign load      = accept && func3_legal(bus.func3);
    assign step      = (state_reg == RUN) && !bus.flush;
    assign last_step = (cnt_reg == CNT_W'(DATA_W - 1));

    mul_shift_add_dp #(
        .DATA_W (DATA_W)
    ) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .load_a    (bus.op_a),
        .load_b    (bus.op_b),
        .prod_next (prod_next)
    );

    // Result is captured from the final step so it is already valid in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            func3_reg  <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            busy_reg <= 1'b0;
            if (bus.flush) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start) begin
                            if (func3_legal(bus.func3)) begin
                                func3_reg <= bus.func3;
                                cnt_reg   <= '0;
                                busy_reg  <= 1'b1;
                                state_reg <= RUN;
                            end else begin
                                result_reg <= '0;
                                done_reg   <= 1'b1;
                                state_reg  <= DONE;
                            end
                        end
                    end
                    RUN: begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (last_step) begin
                            result_reg <= (func3_reg == FUNC3_MULHU)
                                        ? prod_next[2*DATA_W-1:DATA_W]
                                        : prod_next[DATA_W-1:0];
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            busy_reg <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.stall  = accept || busy_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;

endmodule
